// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : Buffered 8N1 UART transmitter. Byte pushes land in a circular
//               FIFO; a serializer drains it back-to-back onto uart_tx, so the
//               writer never waits on the line rate.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          uart_tx
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int c_AW           = $clog2(FIFO_DEPTH);
    localparam int c_BW           = $clog2(c_CLKS_PER_BIT);

    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(c_CLKS_PER_BIT - 1);
    localparam logic [c_AW:0]   c_FULL_CNT  = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;

    logic [1:0]      r_state;
    logic [7:0]      r_sr;
    logic [2:0]      r_bit_idx;
    logic [c_BW-1:0] r_baud_cnt;
    logic            r_tx;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_baud_last;
    logic [7:0]      w_head;

    // Status flags come from the registered occupancy only, never from this cycle's request.
    assign w_full      = (r_count == c_FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_baud_last = (r_baud_cnt == c_BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr];

    // A full FIFO drops the push even if the serializer pops in the same cycle.
    assign w_push = wr_en && !w_full;
    assign w_pop  = !w_empty && ((r_state == c_S_IDLE) ||
                                 ((r_state == c_S_STOP) && w_baud_last));

    // Storage array: written on accepted pushes, no reset needed for the data itself.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the one-cycle overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en && w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer: the line register is updated together with the state so each
    // bit boundary and the line transition happen on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_sr       <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_sr       <= w_head;
                        r_baud_cnt <= '0;
                        r_state    <= c_S_START;
                        r_tx       <= 1'b0;
                    end
                end
                c_S_START: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= c_S_DATA;
                        r_tx       <= r_sr[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BW'(1);
                    end
                end
                c_S_DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_sr[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BW'(1);
                    end
                end
                c_S_STOP: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        // Chain straight into the next frame when data is waiting.
                        if (!w_empty) begin
                            r_sr    <= w_head;
                            r_state <= c_S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BW'(1);
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign busy     = (r_state != c_S_IDLE);
    assign overflow = r_overflow;
    assign uart_tx  = r_tx;

endmodule
`default_nettype wire
